// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM encoding, timeout default
// and the latched request record.
package alu_pkg;

    localparam int TIMEOUT_DEF = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    typedef struct packed {
        logic       id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto a single ALU, one operation in flight, with
// divide-by-zero short-circuit and a MUL/DIV completion timeout.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e        state, state_nxt;
    req_t          cur_q, sel;
    logic          last_q;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [15:0]   res_q;
    logic          err_q;
    logic [1:0]    gnt;
    logic          idle, accept, div0, addsub, timed_out;

    rr_arbiter2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign idle      = (state == S_IDLE);
    assign accept    = idle & (|gnt);
    assign div0      = (cur_q.op == OP_DIV) && (cur_q.b == 8'd0);
    assign addsub    = ~cur_q.op[1];
    assign cnt_nxt   = cnt_q + CW'(1);
    // cnt_nxt is the 1-based index of the current WAIT cycle
    assign timed_out = (cnt_nxt == CW'(TIMEOUT));

    always_comb begin
        sel = gnt[1] ? '{id: 1'b1, op: req1_op, a: req1_a, b: req1_b}
                     : '{id: 1'b0, op: req0_op, a: req0_a, b: req0_b};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = div0 ? S_RESP : S_WAIT;
            S_WAIT:  if (addsub || alu_done || timed_out) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q  <= '0;
            last_q <= 1'b1;
            cnt_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                cur_q  <= sel;
                last_q <= gnt[1];
            end
            case (state)
                S_ISSUE: begin
                    cnt_q <= '0;
                    if (div0) begin
                        res_q <= 16'hFFFF;
                        err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_nxt;
                    // completion beats timeout when both land in the same cycle
                    if (addsub || alu_done) begin
                        res_q <= alu_result;
                        err_q <= 1'b0;
                    end else if (timed_out) begin
                        res_q <= 16'h0000;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = idle & gnt[0];
    assign req1_ready = idle & gnt[1];
    assign alu_start  = (state == S_ISSUE) & ~div0;
    assign alu_op     = cur_q.op;
    assign alu_a      = cur_q.a;
    assign alu_b      = cur_q.b;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_id     = cur_q.id;
    assign rsp_result = res_q;
    assign rsp_err    = err_q;
    assign busy       = ~idle;

endmodule
